// File: rtl/alu_pkg.sv
// Shared ALU definitions: normalizer FSM states, datapath width and count-width helper.
package alu_pkg;

    typedef enum logic [1:0] {
        NORM_IDLE,
        NORM_SHIFT,
        NORM_DONE
    } norm_state_t;

    localparam int ALU_W = 8;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/norm_shift_step.sv
// One normalization step: shifts the work word toward the stop bit and reports hit/zero.
module norm_shift_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] work,
    input  logic             dir,
    output logic [WIDTH-1:0] next_work,
    output logic             hit,
    output logic             is_zero
);

    // dir=1 normalizes toward the LSB; dir=0 toward the MSB
    always_comb begin
        next_work = dir ? (work >> 1) : (work << 1);
        hit       = dir ? work[0] : work[WIDTH-1];
        is_zero   = (work == '0);
    end

endmodule

// File: rtl/alu_normalizer.sv
// Sequential normalizer: shifts one bit per clock until the stop bit is set and reports the count.
// Optional NORM_RIGHT_EN adds in_dir for trailing-zero (toward LSB) normalization.
module alu_normalizer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef NORM_RIGHT_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    norm_state_t      state;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] count;
    logic             zero;
    logic             dir_q;
    logic [WIDTH-1:0] next_work;
    logic             hit;
    logic             is_zero;

    norm_shift_step #(.WIDTH(WIDTH)) u_step (
        .work      (work),
        .dir       (dir_q),
        .next_work (next_work),
        .hit       (hit),
        .is_zero   (is_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= NORM_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            work      <= '0;
            count     <= '0;
            zero      <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            case (state)
                NORM_IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= in_data;
                        count    <= '0;
                        zero     <= 1'b0;
`ifdef NORM_RIGHT_EN
                        dir_q    <= in_dir;
`else
                        dir_q    <= 1'b0;
`endif
                        in_ready <= 1'b0;
                        state    <= NORM_SHIFT;
                    end
                end
                NORM_SHIFT: begin
                    if (is_zero) begin
                        count     <= CNT_W'(WIDTH);
                        zero      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= NORM_DONE;
                    end else if (hit) begin
                        out_valid <= 1'b1;
                        state     <= NORM_DONE;
                    end else begin
                        work  <= next_work;
                        count <= count + 1'b1;
                    end
                end
                NORM_DONE: begin
                    // in_ready comes back registered, one cycle after the handoff
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= NORM_IDLE;
                    end
                end
                default: begin
                    state     <= NORM_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = work;
    assign out_count = count;
    assign out_zero  = zero;

endmodule
